// File: rtl/game_pkg.sv
// Shared game definitions: opcodes, direction and page codes, instruction field
// positions and the player life-state encoding.
package game_pkg;

    typedef enum logic [3:0] {
        OP_IDLE = 4'd0,
        OP_HPY  = 4'd1,
        OP_DPY  = 4'd2,
        OP_IDG  = 4'd3,
        OP_SDG  = 4'd4,
        OP_MOV  = 4'd5,
        OP_SHP  = 4'd6
    } op_e;

    localparam logic [7:0] DIR_UP    = 8'd0;
    localparam logic [7:0] DIR_LEFT  = 8'd1;
    localparam logic [7:0] DIR_DOWN  = 8'd2;
    localparam logic [7:0] DIR_RIGHT = 8'd3;

    typedef enum logic [1:0] {
        PAGE_TITLE = 2'd0,
        PAGE_MENU  = 2'd1,
        PAGE_DODGE = 2'd2,
        PAGE_OVER  = 2'd3
    } page_e;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int ARG_MSB = 11;
    localparam int ARG_LSB = 4;

    typedef enum logic {
        ST_ALIVE = 1'b0,
        ST_DEAD  = 1'b1
    } life_e;

    function automatic logic [15:0] make_instr(op_e op, logic [7:0] arg);
        return {op, arg, 4'b0000};
    endfunction

endpackage

// File: rtl/player_executor_if.sv
// Game-machine <-> player executor bundle: instruction in, soul position/HP/status out.
interface player_executor_if;
    logic [15:0] playerInstruction;
    logic        isMove;
    logic        startDmg;
    logic [9:0]  posX;
    logic [9:0]  posY;
    logic [7:0]  hp;
    logic        isDeath;
    logic        dmgAck;
    logic        iframe;

    modport master (
        output playerInstruction, isMove, startDmg,
        input  posX, posY, hp, isDeath, dmgAck, iframe
    );

    modport slave (
        input  playerInstruction, isMove, startDmg,
        output posX, posY, hp, isDeath, dmgAck, iframe
    );
endinterface

// File: rtl/axis_clamp_step.sv
// One-axis position stepper: moves pos by +/-STEP when enabled, clamped to [MIN, MAX].
module axis_clamp_step #(
    parameter int STEP = 2,
    parameter int MIN  = 0,
    parameter int MAX  = 1023
) (
    input  logic [9:0] pos_i,
    input  logic       en_i,
    input  logic       dec_i,
    output logic [9:0] pos_o
);
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic signed [11:0] MIN_S  = 12'(MIN);
    localparam logic signed [11:0] MAX_S  = 12'(MAX);

    logic signed [11:0] pos_s;
    logic signed [11:0] sum_s;

    always_comb begin
        pos_s = signed'({2'b00, pos_i});
        sum_s = dec_i ? (pos_s - STEP_S) : (pos_s + STEP_S);
        if (!en_i)
            pos_o = pos_i;
        else if (sum_s < MIN_S)
            pos_o = MIN_S[9:0];
        else if (sum_s > MAX_S)
            pos_o = MAX_S[9:0];
        else
            pos_o = sum_s[9:0];
    end
endmodule

// File: rtl/player_executor.sv
// Executes player instructions (HP ops and arena moves) and tracks death.
// Optional invincibility frames after damage: define PLAYER_IFRAME_EN.
module player_executor
    import game_pkg::*;
#(
    parameter int HP_MAX     = 100,
    parameter int X_MIN      = 220,
    parameter int X_MAX      = 420,
    parameter int Y_MIN      = 260,
    parameter int Y_MAX      = 400,
    parameter int X_INIT     = 320,
    parameter int Y_INIT     = 330,
    parameter int STEP       = 2,
    parameter int MOVE_DIV   = 4,
    parameter int IFRAME_CYC = 50
) (
    input  logic               clk,
    input  logic               rst,
    player_executor_if.slave   bus
);
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    function automatic logic [7:0] hp_add_sat(logic [7:0] a, logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 9'(HP_MAX)) ? 8'(HP_MAX) : s[7:0];
    endfunction

    function automatic logic [7:0] hp_sub_sat(logic [7:0] a, logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} - {1'b0, b};
        return s[8] ? 8'd0 : s[7:0];
    endfunction

    function automatic logic [7:0] hp_set_sat(logic [7:0] a);
        return ({1'b0, a} > 9'(HP_MAX)) ? 8'(HP_MAX) : a;
    endfunction

    life_e            state_q, state_d;
    logic [7:0]       hp_q, hp_d;
    logic [9:0]       x_q, x_d, y_q, y_d;
    logic             ack_q, ack_d;
    logic [DIV_W-1:0] div_q, div_d;

    logic [3:0] op;
    logic [7:0] arg;
    logic       alive, hp_op, mov_qual, move_fire;
    logic [9:0] x_next, y_next;
    logic       ifr_active;

`ifdef PLAYER_IFRAME_EN
    localparam int IFR_W = $clog2(IFRAME_CYC + 1);
    logic [IFR_W-1:0] ifr_q, ifr_d;
    assign ifr_active = (ifr_q != '0);
`else
    assign ifr_active = 1'b0;
`endif

    assign op        = bus.playerInstruction[OP_MSB:OP_LSB];
    assign arg       = bus.playerInstruction[ARG_MSB:ARG_LSB];
    assign alive     = (state_q == ST_ALIVE);
    assign hp_op     = bus.startDmg && alive;
    assign mov_qual  = bus.isMove && (op == OP_MOV) && !bus.startDmg && alive;
    assign move_fire = mov_qual && (div_q == '0);

    axis_clamp_step #(.STEP(STEP), .MIN(X_MIN), .MAX(X_MAX)) u_axis_x (
        .pos_i (x_q),
        .en_i  (move_fire && (arg == DIR_LEFT || arg == DIR_RIGHT)),
        .dec_i (arg == DIR_LEFT),
        .pos_o (x_next)
    );

    axis_clamp_step #(.STEP(STEP), .MIN(Y_MIN), .MAX(Y_MAX)) u_axis_y (
        .pos_i (y_q),
        .en_i  (move_fire && (arg == DIR_UP || arg == DIR_DOWN)),
        .dec_i (arg == DIR_UP),
        .pos_o (y_next)
    );

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        x_d     = x_q;
        y_d     = y_q;
        ack_d   = 1'b0;
        div_d   = div_q;
`ifdef PLAYER_IFRAME_EN
        ifr_d   = ifr_active ? ifr_q - 1'b1 : ifr_q;
`endif
        if (hp_op) begin
            // Divider is deliberately left untouched: a held MOV resumes its cadence.
            ack_d = 1'b1;
            case (op)
                OP_HPY: hp_d = hp_add_sat(hp_q, arg);
                OP_SHP: hp_d = hp_set_sat(arg);
                OP_DPY: begin
                    if (!ifr_active) begin
                        hp_d = hp_sub_sat(hp_q, arg);
`ifdef PLAYER_IFRAME_EN
                        if (arg != 8'd0 && hp_d != 8'd0)
                            ifr_d = IFR_W'(IFRAME_CYC);
`endif
                    end
                end
                default: ;
            endcase
            if (hp_d == 8'd0)
                state_d = ST_DEAD;
        end else if (mov_qual) begin
            if (div_q == '0) begin
                x_d   = x_next;
                y_d   = y_next;
                div_d = DIV_W'(MOVE_DIV - 1);
            end else begin
                div_d = div_q - 1'b1;
            end
        end else begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ALIVE;
            hp_q    <= 8'(HP_MAX);
            x_q     <= 10'(X_INIT);
            y_q     <= 10'(Y_INIT);
            ack_q   <= 1'b0;
            div_q   <= '0;
`ifdef PLAYER_IFRAME_EN
            ifr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ack_q   <= ack_d;
            div_q   <= div_d;
`ifdef PLAYER_IFRAME_EN
            ifr_q   <= ifr_d;
`endif
        end
    end

    assign bus.posX    = x_q;
    assign bus.posY    = y_q;
    assign bus.hp      = hp_q;
    assign bus.isDeath = (state_q == ST_DEAD);
    assign bus.dmgAck  = ack_q;
    assign bus.iframe  = ifr_active;
endmodule

// File: tb/tb_player_executor.sv
// Bench for player_executor: directed vectors, a behavioural model compared every
// cycle, and literal expectations at the key points of each scenario.
module tb_player_executor;
    import game_pkg::*;

    localparam int HP_MAX = 100, X_MIN = 220, X_MAX = 420, Y_MIN = 260, Y_MAX = 400;
    localparam int X_INIT = 320, Y_INIT = 330, STEP = 2, MOVE_DIV = 4, IFRAME_CYC = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    player_executor_if bus ();

    player_executor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [9:0] cl_pos;
    logic       cl_en, cl_dec;
    logic [9:0] cl_out;
    axis_clamp_step #(.STEP(STEP), .MIN(X_MIN), .MAX(X_MAX)) u_clamp (
        .pos_i (cl_pos),
        .en_i  (cl_en),
        .dec_i (cl_dec),
        .pos_o (cl_out)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: HP rules, life, and a count of consecutive held-MOV cycles.
    int m_hp, m_x, m_y, m_ack, m_dead, m_ifr, m_hold;

    always @(posedge clk) begin
        int op, arg, nh;
        bit inv, start;
        op  = int'(bus.playerInstruction[15:12]);
        arg = int'(bus.playerInstruction[11:4]);
        if (rst) begin
            m_hp = HP_MAX; m_x = X_INIT; m_y = Y_INIT;
            m_ack = 0; m_dead = 0; m_ifr = 0; m_hold = 0;
        end else begin
`ifdef PLAYER_IFRAME_EN
            inv = (m_ifr > 0);
`else
            inv = 1'b0;
`endif
            start = 1'b0;
            m_ack = 0;
            if (!m_dead && bus.startDmg) begin
                m_ack = 1;
                if (op == 1) begin
                    m_hp = (m_hp + arg > HP_MAX) ? HP_MAX : m_hp + arg;
                end else if (op == 2) begin
                    if (!inv) begin
                        nh = (arg >= m_hp) ? 0 : m_hp - arg;
                        if (arg > 0 && nh > 0) start = 1'b1;
                        m_hp = nh;
                    end
                end else if (op == 6) begin
                    m_hp = (arg > HP_MAX) ? HP_MAX : arg;
                end
                if (m_hp == 0) m_dead = 1;
            end else if (!m_dead && bus.isMove && op == 5) begin
                if (m_hold % MOVE_DIV == 0) begin
                    case (arg)
                        0: m_y = (m_y - STEP < Y_MIN) ? Y_MIN : m_y - STEP;
                        1: m_x = (m_x - STEP < X_MIN) ? X_MIN : m_x - STEP;
                        2: m_y = (m_y + STEP > Y_MAX) ? Y_MAX : m_y + STEP;
                        3: m_x = (m_x + STEP > X_MAX) ? X_MAX : m_x + STEP;
                        default: ;
                    endcase
                end
                m_hold++;
            end else begin
                m_hold = 0;
            end
`ifdef PLAYER_IFRAME_EN
            if (start) m_ifr = IFRAME_CYC;
            else if (m_ifr > 0) m_ifr--;
`else
            m_ifr = 0;
`endif
        end
    end

    always @(negedge clk) begin
        check("posX", int'(bus.posX), m_x);
        check("posY", int'(bus.posY), m_y);
        check("hp", int'(bus.hp), m_hp);
        check("isDeath", int'(bus.isDeath), m_dead);
        check("dmgAck", int'(bus.dmgAck), m_ack);
        check("iframe", int'(bus.iframe), (m_ifr > 0) ? 1 : 0);
    end

    task automatic cyc(input logic [15:0] ins, input logic mv, input logic sd);
        bus.playerInstruction = ins;
        bus.isMove            = mv;
        bus.startDmg          = sd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(16'h0000, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        bus.playerInstruction = 16'h0000;
        bus.isMove = 1'b0;
        bus.startDmg = 1'b0;
        cl_pos = 10'd0; cl_en = 1'b0; cl_dec = 1'b0;

        // Scenario 1: reset state, SHP 0 kills, dead player ignores HPY and MOV.
        do_reset();
        check("rst_hp", int'(bus.hp), 100);
        check("rst_posX", int'(bus.posX), 320);
        check("rst_posY", int'(bus.posY), 330);
        check("rst_death", int'(bus.isDeath), 0);
        check("rst_ack", int'(bus.dmgAck), 0);
        check("rst_iframe", int'(bus.iframe), 0);
        cyc(make_instr(OP_SHP, 8'd0), 1'b0, 1'b1);
        check("shp0_hp", int'(bus.hp), 0);
        check("shp0_death", int'(bus.isDeath), 1);
        check("shp0_ack", int'(bus.dmgAck), 1);
        cyc(make_instr(OP_HPY, 8'd10), 1'b0, 1'b1);
        check("dead_hpy_hp", int'(bus.hp), 0);
        check("dead_hpy_ack", int'(bus.dmgAck), 0);
        cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        check("dead_mov_x", int'(bus.posX), 320);

        // Scenario 2: DPY 30, then DPY 30 at +5 and +51 cycles.
        do_reset();
        cyc(make_instr(OP_DPY, 8'd30), 1'b0, 1'b1);
        check("dpy30_hp", int'(bus.hp), 70);
        check("dpy30_ack", int'(bus.dmgAck), 1);
        idle(4);
        check("ack_cleared", int'(bus.dmgAck), 0);
        cyc(make_instr(OP_DPY, 8'd30), 1'b0, 1'b1);
`ifdef PLAYER_IFRAME_EN
        check("dpy_p5_hp", int'(bus.hp), 70);
        check("dpy_p5_iframe", int'(bus.iframe), 1);
`else
        check("dpy_p5_hp", int'(bus.hp), 40);
        check("dpy_p5_iframe", int'(bus.iframe), 0);
`endif
        check("dpy_p5_ack", int'(bus.dmgAck), 1);
        idle(45);
        cyc(make_instr(OP_DPY, 8'd30), 1'b0, 1'b1);
`ifdef PLAYER_IFRAME_EN
        check("dpy_p51_hp", int'(bus.hp), 40);
`else
        check("dpy_p51_hp", int'(bus.hp), 10);
`endif

        // Scenario 3: HPY saturates at HP_MAX, oversize DPY floors at 0.
        do_reset();
        cyc(make_instr(OP_DPY, 8'd5), 1'b0, 1'b1);
        check("hp95", int'(bus.hp), 95);
        idle(60);
        cyc(make_instr(OP_HPY, 8'd10), 1'b0, 1'b1);
        check("hpy_sat", int'(bus.hp), 100);
        cyc(make_instr(OP_SHP, 8'd250), 1'b0, 1'b1);
        check("shp_sat", int'(bus.hp), 100);
        cyc(make_instr(OP_DPY, 8'd200), 1'b0, 1'b1);
        check("dpy200_hp", int'(bus.hp), 0);
        check("dpy200_death", int'(bus.isDeath), 1);
        check("dpy200_iframe", int'(bus.iframe), 0);

        // Scenario 4: held MOV cadence, clamping, release and IDLE clearing the divider.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
            if (i == 0) check("mov_c1", int'(bus.posX), 322);
            if (i == 3) check("mov_c4", int'(bus.posX), 322);
            if (i == 4) check("mov_c5", int'(bus.posX), 324);
            if (i == 8) check("mov_c9", int'(bus.posX), 326);
            if (i == 11) check("mov_c12", int'(bus.posX), 326);
        end
        idle(1);
        for (int i = 0; i < 200; i++) cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        check("clamp_xmax", int'(bus.posX), 420);
        idle(1);
        cyc(make_instr(OP_MOV, DIR_LEFT), 1'b1, 1'b0);
        check("repress_left", int'(bus.posX), 418);
        cyc(16'h0000, 1'b1, 1'b0);
        cyc(make_instr(OP_MOV, DIR_LEFT), 1'b1, 1'b0);
        check("idle_clears_div", int'(bus.posX), 416);
        idle(1);
        cyc(make_instr(OP_MOV, 8'd7), 1'b1, 1'b0);
        check("bad_dir_x", int'(bus.posX), 416);
        check("bad_dir_y", int'(bus.posY), 330);
        idle(1);
        for (int i = 0; i < 150; i++) cyc(make_instr(OP_MOV, DIR_UP), 1'b1, 1'b0);
        check("clamp_ymin", int'(bus.posY), 260);
        idle(1);
        for (int i = 0; i < 5; i++) cyc(make_instr(OP_MOV, DIR_DOWN), 1'b1, 1'b0);
        check("down_two", int'(bus.posY), 264);

        // Scenario 5: simultaneous HP op and isMove; divider holds across it.
        do_reset();
        cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        check("sim_pre_x", int'(bus.posX), 322);
        cyc(make_instr(OP_DPY, 8'd5), 1'b1, 1'b1);
        check("sim_hp", int'(bus.hp), 95);
        check("sim_x", int'(bus.posX), 322);
        check("sim_y", int'(bus.posY), 330);
        for (int i = 0; i < 3; i++) cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        check("sim_hold_x", int'(bus.posX), 322);
        cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        check("sim_resume_x", int'(bus.posX), 324);

        // Scenario 6: reset during iframe and a held MOV.
        do_reset();
        cyc(make_instr(OP_DPY, 8'd10), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        rst = 1'b1;
        cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        check("rst6_hp", int'(bus.hp), 100);
        check("rst6_x", int'(bus.posX), 320);
        check("rst6_iframe", int'(bus.iframe), 0);
        check("rst6_ack", int'(bus.dmgAck), 0);
        rst = 1'b0;
        cyc(make_instr(OP_MOV, DIR_RIGHT), 1'b1, 1'b0);
        check("rst6_fresh_x", int'(bus.posX), 322);
        idle(2);

        // Direct clamp checks on odd positions that the default arena cannot reach.
        cl_pos = 10'd419; cl_en = 1'b1; cl_dec = 1'b0; #1;
        check("clamp_419_up", int'(cl_out), 420);
        cl_pos = 10'd221; cl_dec = 1'b1; #1;
        check("clamp_221_dn", int'(cl_out), 220);
        cl_pos = 10'd300; cl_dec = 1'b0; #1;
        check("clamp_300_up", int'(cl_out), 302);
        cl_en = 1'b0; #1;
        check("clamp_dis", int'(cl_out), 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
